uart_rx: RTL and testbench

Asynchronous serial receiver for 8N1-style framing. Oversamples the `rx_i` line with a fixed clocks-per-bit divider, samples each bit at its midpoint, and delivers each received word on a single-entry valid/ready output. It is the receive end of the serial link whose transmit side drives the same line format. It sits between the board pin and the internal byte-stream consumers.

---
 rtl/sv_pkg.sv | 13 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sv_pkg.sv
// Shared types and sizing helpers for the serial receive path.
package sv_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: mid-bit sampling with a fixed divider and a
// single-entry valid/ready output register with frame-error and overrun pulses.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on the synchronized input
// START | counting to the start-bit midpoint to reject glitches
// DATA  | sampling data bits one full bit period apart, LSB first
// STOP  | sampling the stop bit; high completes the word
// BREAK | stop bit was low; wait for the line to return high
module uart_rx import sv_pkg::*; #(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int IW = cnt_width(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_rx_state_t       state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 word_done;
    logic                 frame_err_q;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx_i),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            word_done   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            word_done   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        // shift in at the top so the first (LSB) bit ends at bit 0
                        shreg <= DATA_BITS'({rx_s, shreg} >> 1);
                        idx   <= idx + IW'(1);
                        if (idx == IDX_LAST) state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt <= '0;
                        if (rx_s) begin
                            word_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // shreg is untouched for at least half a bit after word_done, so it is safe to load here
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= frame_err_q;
            overrun_o   <= 1'b0;
            if (word_done) begin
                if (!valid_o || ready_i) begin
                    data_o  <= shreg;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed framing/timing cases plus randomized bursts with baud error.
`timescale 1ps/1ps
module tb_uart_rx;

    localparam int N      = 16;
    localparam int H      = N / 2;
    localparam int LAT    = 3 + H + 9 * N;
    localparam int BIT_PS = N * 10000;
    localparam byte F_FERR = 8'd1;
    localparam byte F_OVR  = 8'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overrun_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    byte unsigned word_q[$];
    byte unsigned flag_q[$];

    int  valid_hi_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;
    int  rise_cyc = -1, ferr_cyc = -1;
    logic valid_prev = 1'b0;

    uart_rx #(.CLKS_PER_BIT(N), .DATA_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    always #5000 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_flag(input string name, input byte unsigned kind);
        byte unsigned e;
        checks++;
        if (flag_q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected: got pulse, expected none at cycle %0d", name, cyc);
        end else begin
            e = flag_q.pop_front();
            if (e != kind) begin
                errors++;
                $display("FAIL %s_kind: got flag %0d, expected flag %0d", name, kind, e);
            end
        end
    endtask

    // monitor: sample at the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        byte unsigned ew;
        if (!rst) begin
            if (valid_o) valid_hi_cnt++;
            if (valid_o && !valid_prev) rise_cyc = cyc;
            if (valid_o && ready_i) begin
                checks++;
                if (word_q.size() == 0) begin
                    errors++;
                    $display("FAIL word_unexpected: got %02h, expected no word", data_o);
                end else begin
                    ew = word_q.pop_front();
                    if (data_o !== ew) begin
                        errors++;
                        $display("FAIL word_data: got %02h, expected %02h", data_o, ew);
                    end
                end
            end
            if (frame_err_o) begin
                ferr_cnt++;
                ferr_cyc = cyc;
                check_flag("frame_err", F_FERR);
            end
            if (overrun_o) begin
                ovr_cnt++;
                check_flag("overrun", F_OVR);
            end
        end
        valid_prev = valid_o;
    end

    task automatic tick();
        @(posedge clk);
        #1000;
    endtask

    // cycle-aligned frame; E is the edge that first captures the start bit
    task automatic send_sync(input logic [7:0] d, input logic stop, input int extra_low, output int e);
        tick();
        rx_i = 1'b0;
        e = cyc + 1;
        repeat (N) tick();
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (N) tick();
        end
        rx_i = stop;
        repeat (N + extra_low) tick();
        rx_i = 1'b1;
    endtask

    // free-running transmitter with its own bit period, unrelated to clk phase
    task automatic send_async(input logic [7:0] d, input bit good, input int bit_ps);
        rx_i = 1'b0;
        #(bit_ps);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            #(bit_ps);
        end
        if (good) begin
            rx_i = 1'b1;
            #(bit_ps);
        end else begin
            rx_i = 1'b0;
            #(bit_ps * int'($urandom_range(1, 3)));
            rx_i = 1'b1;
            #(bit_ps);
        end
        #(bit_ps * int'($urandom_range(0, 2)));
    endtask

    initial begin
        #(64'd2000000000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e, e2, e3, v0, f0, o0, nfr, bit_ps, jit;
        bit mode, good, occupied;
        logic [7:0] d;

        repeat (3) tick();
        @(negedge clk);
        chk("reset_valid", valid_o, 0);
        chk("reset_data", data_o, 0);
        chk("reset_flags", {frame_err_o, overrun_o}, 0);
        tick();
        rst = 1'b0;
        repeat (5) tick();

        // single frame, consumer always ready
        ready_i = 1'b1;
        v0 = valid_hi_cnt;
        word_q.push_back(8'hA5);
        send_sync(8'hA5, 1'b1, 0, e);
        repeat (20) tick();
        chk("a5_rise_cycle", rise_cyc, e + LAT);
        chk("a5_valid_cycles", valid_hi_cnt - v0, 1);

        // glitch shorter than half a bit
        v0 = valid_hi_cnt; f0 = ferr_cnt;
        tick(); rx_i = 1'b0;
        repeat (5) tick();
        rx_i = 1'b1;
        repeat (200) tick();
        chk("glitch_no_valid", valid_hi_cnt - v0, 0);
        chk("glitch_no_ferr", ferr_cnt - f0, 0);

        // bad stop bit followed by a held-low line
        v0 = valid_hi_cnt; f0 = ferr_cnt;
        flag_q.push_back(F_FERR);
        send_sync(8'h3C, 1'b0, 40, e);
        repeat (200) tick();
        chk("ferr_cycle", ferr_cyc, e + LAT);
        chk("ferr_count", ferr_cnt - f0, 1);
        chk("ferr_no_valid", valid_hi_cnt - v0, 0);

        // overrun with consumer stalled
        ready_i = 1'b0;
        o0 = ovr_cnt;
        word_q.push_back(8'h11);
        flag_q.push_back(F_OVR);
        send_sync(8'h11, 1'b1, 0, e);
        send_sync(8'h22, 1'b1, 0, e);
        repeat (10) tick();
        @(negedge clk);
        chk("ovr_data_held", data_o, 8'h11);
        chk("ovr_valid_held", valid_o, 1);
        chk("ovr_count", ovr_cnt - o0, 1);
        tick(); ready_i = 1'b1;
        tick(); ready_i = 1'b0;
        @(negedge clk);
        chk("ovr_valid_drop", valid_o, 0);

        // new word lands in the same cycle the old one is accepted
        o0 = ovr_cnt;
        word_q.push_back(8'h33);
        send_sync(8'h33, 1'b1, 0, e);
        repeat (10) tick();
        word_q.push_back(8'h44);
        e2 = cyc + 2;
        fork
            send_sync(8'h44, 1'b1, 0, e);
            begin
                while (cyc < e2 + LAT - 1) tick();
                ready_i = 1'b1;
                tick();
                ready_i = 1'b0;
            end
        join
        @(negedge clk);
        chk("b2b_data", data_o, 8'h44);
        chk("b2b_valid", valid_o, 1);
        chk("b2b_no_ovr", ovr_cnt - o0, 0);
        tick(); ready_i = 1'b1;
        repeat (5) tick();

        // reset in the middle of data bit 4
        v0 = valid_hi_cnt;
        e3 = cyc + 2;
        fork
            send_sync(8'hFF, 1'b1, 0, e);
            begin
                while (cyc < e3 + 2 + H + 4 * N + 5) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                @(negedge clk);
                chk("rst_data", data_o, 0);
                chk("rst_valid", valid_o, 0);
                chk("rst_flags", {frame_err_o, overrun_o}, 0);
            end
        join
        repeat (200) tick();
        chk("rst_no_valid", valid_hi_cnt - v0, 0);
        word_q.push_back(8'h5A);
        send_sync(8'h5A, 1'b1, 0, e);
        repeat (20) tick();

        // randomized bursts with up to +-3% transmitter bit-period error
        for (int b = 0; b < 10; b++) begin
            mode = bit'($urandom_range(0, 1));
            tick();
            ready_i = mode;
            nfr = int'($urandom_range(2, 5));
            occupied = 1'b0;
            #(int'($urandom_range(0, 9999)));
            for (int f = 0; f < nfr; f++) begin
                d = 8'($urandom);
                good = ($urandom_range(0, 5) != 0);
                jit = int'($urandom_range(0, 9600)) - 4800;
                bit_ps = BIT_PS + jit;
                if (!good) flag_q.push_back(F_FERR);
                else if (mode || !occupied) begin
                    word_q.push_back(d);
                    occupied = !mode;
                end else flag_q.push_back(F_OVR);
                send_async(d, good, bit_ps);
            end
            repeat (20) tick();
            ready_i = 1'b1;
            repeat (20) tick();
        end

        repeat (50) tick();
        chk("words_outstanding", word_q.size(), 0);
        chk("flags_outstanding", flag_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
